// File: rtl/da_pkg.sv
// Shared constants, word types and FSM encoding for the distributed-arithmetic 4-tap FIR.
package da_pkg;
    localparam int XW        = 8;
    localparam int CW        = 32;
    localparam int OW        = CW + XW + 2;
    localparam int TAPS      = 4;
    localparam int LUT_DEPTH = 16;
    localparam int BW        = $clog2(XW);

    typedef logic signed [XW-1:0] sample_t;
    typedef logic signed [CW-1:0] coef_t;
    typedef logic signed [OW-1:0] acc_t;
    typedef logic [BW-1:0]        bit_idx_t;
    typedef logic [TAPS-1:0]      lut_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUILD,
        ST_WAIT,
        ST_COMPUTE,
        ST_HOLD
    } state_t;

    // Coefficient that LUT entry k adds on top of entry k & (k-1); k is never 0 here.
    function automatic logic [1:0] lowest_set_bit(input lut_addr_t k);
        logic [1:0] idx;
        idx = 2'd3;
        for (int i = TAPS - 1; i >= 0; i--) begin
            if (k[i]) idx = 2'(i);
        end
        return idx;
    endfunction
endpackage

// File: rtl/da_lut_builder.sv
// Coefficient registers plus the 16-entry partial-sum LUT, filled one entry per cycle on request.
module da_lut_builder
    import da_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coef_we_i,
    input  logic [1:0] coef_addr_i,
    input  coef_t      coef_data_i,
    input  logic       build_start_i,
    output logic       build_done_o,
    input  lut_addr_t  rd_addr_i,
    output acc_t       rd_data_o
);
    coef_t     coef_q [TAPS];
    acc_t      lut_q  [LUT_DEPTH];
    lut_addr_t k_q;
    logic      building_q;
    acc_t      entry_d;

    // Each entry reuses an already-built entry with its lowest bit cleared, so one adder suffices.
    always_comb begin
        entry_d = lut_q[k_q & (k_q - lut_addr_t'(1))] + acc_t'(coef_q[lowest_set_bit(k_q)]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < TAPS; j++) coef_q[j] <= '0;
        end else if (coef_we_i) begin
            coef_q[coef_addr_i] <= coef_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
            k_q        <= '0;
            building_q <= 1'b0;
        end else if (build_start_i) begin
            k_q        <= lut_addr_t'(1);
            building_q <= 1'b1;
        end else if (building_q) begin
            lut_q[k_q] <= entry_d;
            k_q        <= k_q + lut_addr_t'(1);
            if (k_q == lut_addr_t'(LUT_DEPTH - 1)) building_q <= 1'b0;
        end
    end

    assign build_done_o = building_q && (k_q == lut_addr_t'(LUT_DEPTH - 1));
    assign rd_data_o    = lut_q[rd_addr_i];
endmodule

// File: rtl/da_fir_sequencer.sv
// 4-tap DA FIR: sequencing FSM, sample delay line and bit-serial MSB-first accumulator.
module da_fir_sequencer
    import da_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_addr,
    input  logic [CW-1:0] cfg_data,
    input  logic          cfg_commit,
    output logic          cfg_busy,
    output logic          lut_valid,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data
);
    state_t    state_q, state_d;
    sample_t   taps_q [TAPS];
    bit_idx_t  b_q;
    acc_t      acc_q, acc_d, p_q, lut_rd, out_data_q;
    logic      p_vld_q, p_sign_q, p_last_q;
    logic      out_valid_q, lut_valid_q, pending_q;
    logic      accept, out_hs, build_start, build_done;
    lut_addr_t rd_addr;

    assign accept      = (state_q == ST_WAIT) && in_valid;
    assign out_hs      = (state_q == ST_HOLD) && out_valid_q && out_ready;
    assign build_start = (state_d == ST_BUILD) && (state_q != ST_BUILD);

    da_lut_builder u_lut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coef_we_i    (cfg_we && !cfg_busy),
        .coef_addr_i  (cfg_addr),
        .coef_data_i  (coef_t'(cfg_data)),
        .build_start_i(build_start),
        .build_done_o (build_done),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (lut_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (cfg_commit) state_d = ST_BUILD;
            ST_BUILD:   if (build_done) state_d = ST_WAIT;
            ST_WAIT: begin
                if (accept)          state_d = ST_COMPUTE;
                else if (cfg_commit) state_d = ST_BUILD;
            end
            ST_COMPUTE: if (b_q == '0) state_d = ST_HOLD;
            ST_HOLD:    if (out_hs) state_d = (pending_q || cfg_commit) ? ST_BUILD : ST_WAIT;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_busy  = (state_q == ST_BUILD) || (state_q == ST_COMPUTE);
        in_ready  = (state_q == ST_WAIT);
        lut_valid = lut_valid_q;
        out_valid = out_valid_q;
        out_data  = out_data_q;
    end

    // The LUT read is registered, so accumulation trails the bit counter by one cycle.
    always_comb begin
        rd_addr = '0;
        for (int j = 0; j < TAPS; j++) rd_addr[j] = taps_q[j][b_q];
        acc_d = acc_q;
        if (p_vld_q) acc_d = p_sign_q ? -p_q : ((acc_q <<< 1) + p_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < TAPS; j++) taps_q[j] <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            p_vld_q     <= 1'b0;
            p_sign_q    <= 1'b0;
            p_last_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            lut_valid_q <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            if (build_start) begin
                for (int j = 0; j < TAPS; j++) taps_q[j] <= '0;
            end else if (accept) begin
                for (int j = TAPS - 1; j > 0; j--) taps_q[j] <= taps_q[j-1];
                taps_q[0] <= sample_t'(in_data);
            end
            if (accept) begin
                b_q   <= bit_idx_t'(XW - 1);
                acc_q <= '0;
            end else begin
                if (state_q == ST_COMPUTE) b_q <= b_q - bit_idx_t'(1);
                acc_q <= acc_d;
            end
            p_q      <= lut_rd;
            p_vld_q  <= (state_q == ST_COMPUTE);
            p_sign_q <= (state_q == ST_COMPUTE) && (b_q == bit_idx_t'(XW - 1));
            p_last_q <= (state_q == ST_COMPUTE) && (b_q == '0);
            if (p_vld_q && p_last_q) begin
                out_data_q  <= acc_d;
                out_valid_q <= 1'b1;
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
            end
            if (build_done) lut_valid_q <= 1'b1;
            // A commit that arrives while a result is outstanding is replayed after its handshake.
            if (accept && cfg_commit)    pending_q <= 1'b1;
            else if (state_q == ST_HOLD) pending_q <= out_hs ? 1'b0 : (pending_q | cfg_commit);
        end
    end
endmodule

// File: tb/tb_da_fir_sequencer.sv
// Randomised self-checking bench for da_fir_sequencer against a plain-arithmetic FIR model.
module tb_da_fir_sequencer;
    import da_pkg::*;

    logic                 clk, rst_n;
    logic                 cfg_we, cfg_commit, cfg_busy, lut_valid;
    logic [1:0]           cfg_addr;
    logic [CW-1:0]        cfg_data;
    logic                 in_valid, in_ready, out_valid, out_ready;
    logic [XW-1:0]        in_data;
    logic signed [OW-1:0] out_data;

    int     checks = 0;
    int     errors = 0;
    longint model_c [TAPS];
    longint lut_c   [TAPS];
    longint hist    [TAPS];

    da_fir_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_commit(cfg_commit),
        .cfg_busy  (cfg_busy),
        .lut_valid (lut_valid),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic writeCoef(input int addr, input longint val);
        cfg_we   = 1'b1;
        cfg_addr = 2'(addr);
        cfg_data = 32'(val);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        model_c[addr] = longint'(signed'(32'(val)));
    endtask

    task automatic doCommit(input bit withWe, input int addr, input longint val);
        int n;
        cfg_commit = 1'b1;
        cfg_we     = withWe;
        cfg_addr   = 2'(addr);
        cfg_data   = 32'(val);
        if (withWe) model_c[addr] = longint'(signed'(32'(val)));
        @(posedge clk); #1;
        cfg_commit = 1'b0;
        cfg_we     = 1'b0;
        for (int j = 0; j < TAPS; j++) begin
            lut_c[j] = model_c[j];
            hist[j]  = 0;
        end
        checkOutput("busy_in_build", longint'(cfg_busy), 1);
        n = 0;
        while (!(lut_valid && in_ready) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("build_complete", longint'(lut_valid && in_ready), 1);
    endtask

    task automatic applyStimulus(input int x, input int holdCycles, input bit pokeCompute);
        int     n;
        longint expv;
        longint firstData;
        bit     changed;
        bit     readySeen;
        n = 0;
        while (!in_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("in_ready_seen", longint'(in_ready), 1);
        if (!in_ready) return;
        out_ready = (holdCycles == 0);
        in_valid  = 1'b1;
        in_data   = 8'(x);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int j = TAPS - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = x;
        expv = 0;
        for (int j = 0; j < TAPS; j++) expv += lut_c[j] * hist[j];
        n = 0;
        while (!out_valid && n < 40) begin
            if (pokeCompute && n == 2) begin
                cfg_we     = 1'b1;
                cfg_addr   = 2'd0;
                cfg_data   = 32'h7ead_beef;
                cfg_commit = 1'b1;
            end
            @(posedge clk); #1;
            cfg_we     = 1'b0;
            cfg_commit = 1'b0;
            n++;
        end
        checkOutput("latency", n, XW + 1);
        checkOutput("out_data", longint'(out_data), expv);
        firstData = longint'(out_data);
        changed   = 1'b0;
        readySeen = 1'b0;
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk); #1;
            if (longint'(out_data) != firstData || !out_valid) changed = 1'b1;
            if (in_ready) readySeen = 1'b1;
        end
        if (holdCycles > 0) begin
            checkOutput("hold_stable", longint'(changed), 0);
            checkOutput("hold_in_ready", longint'(readySeen), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("out_valid_drop", longint'(out_valid), 0);
    endtask

    initial begin
        int  xs [5];
        bit  sawValid, sawReady;
        int  r;
        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_commit = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        for (int j = 0; j < TAPS; j++) begin
            model_c[j] = 0; lut_c[j] = 0; hist[j] = 0;
        end
        #2;
        checkOutput("rst_out_valid", longint'(out_valid), 0);
        checkOutput("rst_out_data", longint'(out_data), 0);
        checkOutput("rst_in_ready", longint'(in_ready), 0);
        checkOutput("rst_lut_valid", longint'(lut_valid), 0);
        checkOutput("rst_cfg_busy", longint'(cfg_busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("idle_in_ready", longint'(in_ready), 0);

        $display("[TB] impulse");
        for (int j = 0; j < TAPS; j++) writeCoef(j, j + 1);
        doCommit(1'b0, 0, 0);
        xs = '{1, 0, 0, 0, 0};
        foreach (xs[i]) applyStimulus(xs[i], 0, 1'b0);

        $display("[TB] sign");
        writeCoef(0, 5);
        for (int j = 1; j < TAPS; j++) writeCoef(j, 0);
        doCommit(1'b0, 0, 0);
        applyStimulus(-128, 0, 1'b0);
        applyStimulus(127, 0, 1'b0);
        for (int j = 0; j < TAPS; j++) writeCoef(j, -1);
        doCommit(1'b0, 0, 0);
        repeat (4) applyStimulus(-128, 0, 1'b0);

        $display("[TB] extremes");
        for (int j = 0; j < TAPS; j++) writeCoef(j, -64'sd2147483648);
        doCommit(1'b0, 0, 0);
        repeat (4) applyStimulus(-128, 0, 1'b0);
        applyStimulus(127, 0, 1'b0);

        $display("[TB] backpressure");
        for (int j = 0; j < TAPS; j++) begin
            r = $urandom();
            writeCoef(j, longint'(r));
        end
        doCommit(1'b0, 0, 0);
        applyStimulus(37, 20, 1'b0);
        applyStimulus(-5, 0, 1'b0);

        $display("[TB] config");
        applyStimulus(12, 0, 1'b1);
        applyStimulus(-3, 0, 1'b0);
        writeCoef(1, 99);
        applyStimulus(1, 0, 1'b0);
        doCommit(1'b1, 0, 7);
        applyStimulus(0, 0, 1'b0);
        applyStimulus(1, 0, 1'b0);
        applyStimulus(0, 0, 1'b0);

        $display("[TB] random");
        for (int round = 0; round < 4; round++) begin
            for (int j = 0; j < TAPS; j++) begin
                r = $urandom();
                writeCoef(j, longint'(r));
            end
            doCommit(1'b0, 0, 0);
            for (int s = 0; s < 6; s++) begin
                applyStimulus(int'($urandom_range(255)) - 128, int'($urandom_range(3)), 1'b0);
            end
        end

        $display("[TB] reset mid-compute");
        in_valid = 1'b1;
        in_data  = 8'd77;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", longint'(out_valid), 0);
        checkOutput("midrst_out_data", longint'(out_data), 0);
        checkOutput("midrst_lut_valid", longint'(lut_valid), 0);
        checkOutput("midrst_in_ready", longint'(in_ready), 0);
        checkOutput("midrst_cfg_busy", longint'(cfg_busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int j = 0; j < TAPS; j++) begin
            model_c[j] = 0; lut_c[j] = 0; hist[j] = 0;
        end
        sawValid = 1'b0;
        sawReady = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) sawValid = 1'b1;
            if (in_ready)  sawReady = 1'b1;
        end
        checkOutput("postrst_no_valid", longint'(sawValid), 0);
        checkOutput("postrst_no_ready", longint'(sawReady), 0);
        writeCoef(2, -9);
        doCommit(1'b0, 0, 0);
        xs = '{4, -6, 100, -1, 0};
        foreach (xs[i]) applyStimulus(xs[i], 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
